mod_operand_fetch: RTL and testbench

- Read side of the architectural register file; producer of the ID_EX operand bundle consumed by execute.
- Takes decoded instructions, reads source operands, and tracks in-flight destination writes with a scoreboard. Stalls on RAW hazards.
- Accepts up to two register writes per cycle from writeback and clears the matching scoreboard bits.
- Holds the 16×64 register array (RAX=0, RDX=2, RSP=4).

---
 rtl/mod_operand_fetch.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_mod_operand_fetch.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_operand_fetch.sv
// -----------------------------------------------------------------------------
// mod_operand_fetch
//
// Read side of the architectural register file. Accepts decoded instructions,
// reads their source operands and produces the operand bundle for execute.
// A per-register scoreboard tracks destinations that are in flight between
// issue and writeback; an instruction whose sources are busy (or overlap the
// bundle currently waiting at the output) is held off with in_ready=0.
// Writeback delivers up to two register writes per cycle; port 1 wins when
// both ports target the same index.
//
// Optional build macro:
//   WB_BYPASS_EN - forward writeback data combinationally into the captured
//                  operands and treat the matching scoreboard bits as already
//                  clear, removing the writeback-to-read bubble.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid / in_ready          decoded-instruction handshake
//   in_opcode, in_regByte,
//   in_rmByte, in_pc             decoded instruction fields
//   out_valid / out_ready        operand-bundle handshake towards execute
//   out_opcode, out_regByte,
//   out_rmByte, out_pc           registered copies of the instruction fields
//   out_reg_val, out_rm_val      regfile[regByte], regfile[rmByte]
//   out_rsp_val, out_rax_val     regfile[4], regfile[0]
//   wb_we0/idx0/data0            writeback port 0
//   wb_we1/idx1/data1            writeback port 1 (priority on equal index)
//   flush                        drop the output bundle
// -----------------------------------------------------------------------------
module mod_operand_fetch #(
  parameter  int              XLEN     = 64,
  parameter  int              NREGS    = 16,
  parameter  logic [XLEN-1:0] RSP_INIT = '0,
  localparam int              IDX_W    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_opcode,
  input  logic [IDX_W-1:0] in_regByte,
  input  logic [IDX_W-1:0] in_rmByte,
  input  logic [XLEN-1:0]  in_pc,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_opcode,
  output logic [IDX_W-1:0] out_regByte,
  output logic [IDX_W-1:0] out_rmByte,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_reg_val,
  output logic [XLEN-1:0]  out_rm_val,
  output logic [XLEN-1:0]  out_rsp_val,
  output logic [XLEN-1:0]  out_rax_val,

  input  logic             wb_we0,
  input  logic [IDX_W-1:0] wb_idx0,
  input  logic [XLEN-1:0]  wb_data0,
  input  logic             wb_we1,
  input  logic [IDX_W-1:0] wb_idx1,
  input  logic [XLEN-1:0]  wb_data1,

  input  logic             flush
);

  localparam logic [IDX_W-1:0] RAX_IDX = IDX_W'(0);
  localparam logic [IDX_W-1:0] RDX_IDX = IDX_W'(2);
  localparam logic [IDX_W-1:0] RSP_IDX = IDX_W'(4);

  localparam logic [7:0] OP_MUL   = 8'd247;
  localparam logic [7:0] OP_LOAD  = 8'd139;
  localparam logic [7:0] OP_STORE = 8'd137;
  localparam logic [7:0] OP_GRP5  = 8'd255;
  localparam logic [7:0] OP_CALL  = 8'd232;

  typedef logic [NREGS-1:0] rmask_t;

  // ---------------------------------------------------------------------------
  // Opcode decode helpers
  // ---------------------------------------------------------------------------
  function automatic rmask_t bit_of(input logic [IDX_W-1:0] idx);
    rmask_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  function automatic logic is_push(input logic [7:0] op);
    return (op >= 8'd80) && (op <= 8'd87);
  endfunction

  function automatic logic is_pop(input logic [7:0] op);
    return (op >= 8'd88) && (op <= 8'd95);
  endfunction

  // Stack-touching instructions implicitly read and write RSP.
  function automatic logic uses_rsp(input logic [7:0] op);
    return is_push(op) || is_pop(op) || (op == OP_GRP5) || (op == OP_CALL);
  endfunction

  function automatic rmask_t dst_mask(input logic [7:0]       op,
                                      input logic [IDX_W-1:0] rg,
                                      input logic [IDX_W-1:0] rm);
    rmask_t m;
    if (op == OP_MUL)       m = bit_of(RAX_IDX) | bit_of(RDX_IDX);
    else if (op == OP_LOAD) m = bit_of(rg);
    else if (op == OP_STORE) m = '0;
    else if (is_pop(op))    m = bit_of(RSP_IDX) | bit_of(rm);
    else if (uses_rsp(op))  m = bit_of(RSP_IDX);
    else                    m = bit_of(rm);
    return m;
  endfunction

  function automatic rmask_t src_mask(input logic [7:0]       op,
                                      input logic [IDX_W-1:0] rg,
                                      input logic [IDX_W-1:0] rm);
    rmask_t m;
    m = bit_of(rg) | bit_of(rm);
    if (uses_rsp(op)) m = m | bit_of(RSP_IDX);
    if (op == OP_MUL) m = m | bit_of(RAX_IDX);
    return m;
  endfunction

`ifdef WB_BYPASS_EN
  // Port 1 is applied last so it wins on an index collision, matching the
  // order in which the register array is written.
  function automatic logic [XLEN-1:0] fwd(input logic [IDX_W-1:0] idx,
                                          input logic [XLEN-1:0]  stored,
                                          input logic             we0,
                                          input logic [IDX_W-1:0] i0,
                                          input logic [XLEN-1:0]  d0,
                                          input logic             we1,
                                          input logic [IDX_W-1:0] i1,
                                          input logic [XLEN-1:0]  d1);
    logic [XLEN-1:0] v;
    v = stored;
    if (we0 && (i0 == idx)) v = d0;
    if (we1 && (i1 == idx)) v = d1;
    return v;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  rf_q [NREGS];
  rmask_t           sb_q;

  logic             vld_p1;
  logic [7:0]       opcode_p1;
  logic [IDX_W-1:0] regbyte_p1;
  logic [IDX_W-1:0] rmbyte_p1;
  logic [XLEN-1:0]  pc_p1;
  logic [XLEN-1:0]  reg_val_p1;
  logic [XLEN-1:0]  rm_val_p1;
  logic [XLEN-1:0]  rsp_val_p1;
  logic [XLEN-1:0]  rax_val_p1;

  logic [XLEN-1:0]  reg_val_p0;
  logic [XLEN-1:0]  rm_val_p0;
  logic [XLEN-1:0]  rsp_val_p0;
  logic [XLEN-1:0]  rax_val_p0;
  rmask_t           sb_view_p0;
  rmask_t           src_p0;
  rmask_t           dst_p1;
  rmask_t           wb_clr;
  logic             hazard_p0;
  logic             capture;
  logic             issue;

  // ---------------------------------------------------------------------------
  // Stage p0: operand read, hazard check, handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_clr = '0;
    if (wb_we0) wb_clr = wb_clr | bit_of(wb_idx0);
    if (wb_we1) wb_clr = wb_clr | bit_of(wb_idx1);
  end

  always_comb begin
`ifdef WB_BYPASS_EN
    reg_val_p0 = fwd(in_regByte, rf_q[in_regByte], wb_we0, wb_idx0, wb_data0,
                     wb_we1, wb_idx1, wb_data1);
    rm_val_p0  = fwd(in_rmByte, rf_q[in_rmByte], wb_we0, wb_idx0, wb_data0,
                     wb_we1, wb_idx1, wb_data1);
    rsp_val_p0 = fwd(RSP_IDX, rf_q[RSP_IDX], wb_we0, wb_idx0, wb_data0,
                     wb_we1, wb_idx1, wb_data1);
    rax_val_p0 = fwd(RAX_IDX, rf_q[RAX_IDX], wb_we0, wb_idx0, wb_data0,
                     wb_we1, wb_idx1, wb_data1);
    // A register being written back right now is already safe to read.
    sb_view_p0 = sb_q & ~wb_clr;
`else
    reg_val_p0 = rf_q[in_regByte];
    rm_val_p0  = rf_q[in_rmByte];
    rsp_val_p0 = rf_q[RSP_IDX];
    rax_val_p0 = rf_q[RAX_IDX];
    sb_view_p0 = sb_q;
`endif
  end

  assign src_p0 = src_mask(in_opcode, in_regByte, in_rmByte);
  assign dst_p1 = dst_mask(opcode_p1, regbyte_p1, rmbyte_p1);

  // The waiting bundle has not set its scoreboard bits yet, so its
  // destinations are checked directly.
  assign hazard_p0 = (|(src_p0 & sb_view_p0)) | (vld_p1 & (|(src_p0 & dst_p1)));

  assign in_ready = reset_n & (~vld_p1 | out_ready) & ~hazard_p0 & ~flush;
  assign capture  = in_valid & in_ready;
  assign issue    = vld_p1 & out_ready & ~flush;

  // ---------------------------------------------------------------------------
  // Register array (writeback port 1 applied last, so it wins)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= (i == int'(RSP_IDX)) ? RSP_INIT : '0;
      end
    end else begin
      if (wb_we0) rf_q[wb_idx0] <= wb_data0;
      if (wb_we1) rf_q[wb_idx1] <= wb_data1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: issue sets after writeback clears, so set wins on a tie
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= (sb_q & ~wb_clr) | (issue ? dst_p1 : '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: operand bundle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (capture) begin
      vld_p1 <= 1'b1;
    end else if (issue) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_p1  <= '0;
      regbyte_p1 <= '0;
      rmbyte_p1  <= '0;
      pc_p1      <= '0;
      reg_val_p1 <= '0;
      rm_val_p1  <= '0;
      rsp_val_p1 <= '0;
      rax_val_p1 <= '0;
    end else if (capture) begin
      opcode_p1  <= in_opcode;
      regbyte_p1 <= in_regByte;
      rmbyte_p1  <= in_rmByte;
      pc_p1      <= in_pc;
      reg_val_p1 <= reg_val_p0;
      rm_val_p1  <= rm_val_p0;
      rsp_val_p1 <= rsp_val_p0;
      rax_val_p1 <= rax_val_p0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_opcode  = opcode_p1;
  assign out_regByte = regbyte_p1;
  assign out_rmByte  = rmbyte_p1;
  assign out_pc      = pc_p1;
  assign out_reg_val = reg_val_p1;
  assign out_rm_val  = rm_val_p1;
  assign out_rsp_val = rsp_val_p1;
  assign out_rax_val = rax_val_p1;

endmodule

// File: tb/tb_mod_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_mod_operand_fetch
//
// Directed scenarios followed by a randomized run. A behavioural model keeps
// the register file as an array, in-flight destinations as a per-register
// pending flag, and register sets as short lists decoded from the opcode.
// -----------------------------------------------------------------------------
module tb_mod_operand_fetch;

  localparam logic [63:0] RSP_INIT = 64'hFEED_0000_0000_1000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_opcode;
  logic [3:0]  in_regByte, in_rmByte;
  logic [63:0] in_pc;
  logic        out_valid, out_ready;
  logic [7:0]  out_opcode;
  logic [3:0]  out_regByte, out_rmByte;
  logic [63:0] out_pc, out_reg_val, out_rm_val, out_rsp_val, out_rax_val;
  logic        wb_we0, wb_we1;
  logic [3:0]  wb_idx0, wb_idx1;
  logic [63:0] wb_data0, wb_data1;
  logic        flush;

  mod_operand_fetch #(.XLEN(64), .NREGS(16), .RSP_INIT(RSP_INIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_regByte(in_regByte), .in_rmByte(in_rmByte), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_regByte(out_regByte), .out_rmByte(out_rmByte), .out_pc(out_pc),
    .out_reg_val(out_reg_val), .out_rm_val(out_rm_val),
    .out_rsp_val(out_rsp_val), .out_rax_val(out_rax_val),
    .wb_we0(wb_we0), .wb_idx0(wb_idx0), .wb_data0(wb_data0),
    .wb_we1(wb_we1), .wb_idx1(wb_idx1), .wb_data1(wb_data1),
    .flush(flush)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic last_rdy;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] n;
    logic [3:0] a, b, c;
  } rset_t;

  logic [63:0] m_rf   [16];
  bit          m_pend [16];
  bit          m_vld;
  logic [7:0]  m_op;
  logic [3:0]  m_rg, m_rm;
  logic [63:0] m_pc, m_regv, m_rmv, m_rspv, m_raxv;

  function automatic bit stack_op(input logic [7:0] op);
    return (op >= 8'd80 && op <= 8'd95) || op == 8'd255 || op == 8'd232;
  endfunction

  function automatic rset_t dst_of(input logic [7:0] op, input logic [3:0] rg, input logic [3:0] rm);
    rset_t s;
    s = '0;
    if (op == 8'd247)                    begin s.n = 2; s.a = 4'd0; s.b = 4'd2; end
    else if (op == 8'd139)               begin s.n = 1; s.a = rg; end
    else if (op == 8'd137)               s.n = 0;
    else if (op >= 8'd88 && op <= 8'd95) begin s.n = 2; s.a = 4'd4; s.b = rm; end
    else if (stack_op(op))               begin s.n = 1; s.a = 4'd4; end
    else                                 begin s.n = 1; s.a = rm; end
    return s;
  endfunction

  function automatic rset_t src_of(input logic [7:0] op, input logic [3:0] rg, input logic [3:0] rm);
    rset_t s;
    s = '0;
    s.n = 2; s.a = rg; s.b = rm;
    if (stack_op(op))       begin s.n = 3; s.c = 4'd4; end
    else if (op == 8'd247)  begin s.n = 3; s.c = 4'd0; end
    return s;
  endfunction

  function automatic logic [3:0] elem(input rset_t s, input int k);
    return (k == 0) ? s.a : (k == 1) ? s.b : s.c;
  endfunction

  function automatic bit in_set(input rset_t s, input logic [3:0] r);
    bit hit;
    hit = 0;
    for (int k = 0; k < int'(s.n); k++) if (elem(s, k) == r) hit = 1;
    return hit;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    logic [63:0] v;
    v = m_rf[idx];
`ifdef WB_BYPASS_EN
    if (wb_we0 && wb_idx0 == idx) v = wb_data0;
    if (wb_we1 && wb_idx1 == idx) v = wb_data1;
`endif
    return v;
  endfunction

  function automatic bit m_ready();
    rset_t s, d;
    bit h, busy;
    logic [3:0] r;
    s = src_of(in_opcode, in_regByte, in_rmByte);
    d = dst_of(m_op, m_rg, m_rm);
    h = 0;
    for (int k = 0; k < int'(s.n); k++) begin
      r = elem(s, k);
      busy = m_pend[r];
`ifdef WB_BYPASS_EN
      if ((wb_we0 && wb_idx0 == r) || (wb_we1 && wb_idx1 == r)) busy = 0;
`endif
      if (busy) h = 1;
      if (m_vld && in_set(d, r)) h = 1;
    end
    return (!m_vld || out_ready) && !h && !flush;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_rf[i]   = (i == 4) ? RSP_INIT : 64'h0;
      m_pend[i] = 0;
    end
    m_vld = 0; m_op = 0; m_rg = 0; m_rm = 0;
    m_pc = 0; m_regv = 0; m_rmv = 0; m_rspv = 0; m_raxv = 0;
  endtask

  task automatic set_idle();
    in_valid = 0; in_opcode = 0; in_regByte = 0; in_rmByte = 0; in_pc = 0;
    out_ready = 0; flush = 0;
    wb_we0 = 0; wb_idx0 = 0; wb_data0 = 0;
    wb_we1 = 0; wb_idx1 = 0; wb_data1 = 0;
  endtask

  task automatic check_outputs();
    check_val("out_valid", out_valid, m_vld);
    if (m_vld) begin
      check_val("out_opcode",  out_opcode,  m_op);
      check_val("out_regByte", out_regByte, m_rg);
      check_val("out_rmByte",  out_rmByte,  m_rm);
      check_val("out_pc",      out_pc,      m_pc);
      check_val("out_reg_val", out_reg_val, m_regv);
      check_val("out_rm_val",  out_rm_val,  m_rmv);
      check_val("out_rsp_val", out_rsp_val, m_rspv);
      check_val("out_rax_val", out_rax_val, m_raxv);
    end
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic tick();
    bit rdy, cap, iss;
    rset_t d_out;
    logic [63:0] c_reg, c_rm, c_rsp, c_rax;
    #1;
    rdy = m_ready();
    last_rdy = in_ready;
    check_val("in_ready", in_ready, rdy);
    cap = in_valid && rdy;
    iss = m_vld && out_ready && !flush;
    d_out = dst_of(m_op, m_rg, m_rm);
    c_reg = m_read(in_regByte);
    c_rm  = m_read(in_rmByte);
    c_rsp = m_read(4'd4);
    c_rax = m_read(4'd0);
    if (wb_we0) m_pend[wb_idx0] = 0;
    if (wb_we1) m_pend[wb_idx1] = 0;
    if (iss) for (int k = 0; k < int'(d_out.n); k++) m_pend[elem(d_out, k)] = 1;
    if (wb_we0) m_rf[wb_idx0] = wb_data0;
    if (wb_we1) m_rf[wb_idx1] = wb_data1;
    if (flush) m_vld = 0;
    else if (cap) begin
      m_vld = 1; m_op = in_opcode; m_rg = in_regByte; m_rm = in_rmByte; m_pc = in_pc;
      m_regv = c_reg; m_rmv = c_rm; m_rspv = c_rsp; m_raxv = c_rax;
    end else if (iss) m_vld = 0;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset_async();
    set_idle();
    reset_n = 0;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready",  in_ready,  0);
    check_val("rst_out_opcode", out_opcode, 0);
    check_val("rst_out_pc",      out_pc,      0);
    check_val("rst_out_reg_val", out_reg_val, 0);
    check_val("rst_out_rsp_val", out_rsp_val, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  // Retire whatever is waiting and write back every pending register.
  task automatic drain();
    set_idle();
    out_ready = 1;
    for (int t = 0; t < 10; t++) begin
      wb_we0 = 0; wb_we1 = 0;
      for (int i = 0; i < 16; i++) begin
        if (m_pend[i] && !wb_we0) begin
          wb_we0 = 1; wb_idx0 = 4'(i); wb_data0 = {$urandom, $urandom};
        end else if (m_pend[i] && !wb_we1) begin
          wb_we1 = 1; wb_idx1 = 4'(i); wb_data1 = {$urandom, $urandom};
        end
      end
      tick();
    end
    set_idle();
  endtask

  task automatic send(input logic [7:0] op, input logic [3:0] rg, input logic [3:0] rm,
                      input logic [63:0] pc);
    in_valid = 1; in_opcode = op; in_regByte = rg; in_rmByte = rm; in_pc = pc;
  endtask

  function automatic logic [3:0] pick_idx();
    int q[$];
    for (int i = 0; i < 16; i++) if (m_pend[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 3) != 0) return 4'(q[$urandom_range(0, q.size() - 1)]);
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic rand_inputs();
    case ($urandom_range(0, 9))
      0: in_opcode = 8'd247;
      1: in_opcode = 8'd139;
      2: in_opcode = 8'd137;
      3: in_opcode = 8'(80 + $urandom_range(0, 7));
      4: in_opcode = 8'(88 + $urandom_range(0, 7));
      5: in_opcode = 8'd255;
      6: in_opcode = 8'd232;
      default: in_opcode = 8'($urandom_range(0, 255));
    endcase
    in_valid   = ($urandom_range(0, 3) != 0);
    in_regByte = 4'($urandom_range(0, 15));
    in_rmByte  = 4'($urandom_range(0, 15));
    in_pc      = {$urandom, $urandom};
    out_ready  = ($urandom_range(0, 3) != 0);
    flush      = ($urandom_range(0, 19) == 0);
    wb_we0     = ($urandom_range(0, 1) == 1);
    wb_idx0    = pick_idx();
    wb_data0   = {$urandom, $urandom};
    wb_we1     = ($urandom_range(0, 2) == 0);
    wb_idx1    = pick_idx();
    wb_data1   = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    reset_n = 1;
    m_reset();
    @(negedge clk);
    do_reset_async();

    // Reset then a read
    send(8'd1, 4'd4, 4'd3, 64'h100);
    tick();
    check_val("rd_valid", out_valid, 1);
    check_val("rd_reg_is_rsp", out_reg_val, RSP_INIT);
    check_val("rd_rm_zero", out_rm_val, 0);
    drain();

    // RAW stall on a load destination
    out_ready = 1;
    send(8'd139, 4'd3, 4'd7, 64'h200);
    tick();
    check_val("raw_first_rdy", last_rdy, 1);
    send(8'd1, 4'd8, 4'd3, 64'h208);
    tick();
    check_val("raw_stall_b", last_rdy, 0);
    tick();
    check_val("raw_stall_c", last_rdy, 0);
    wb_we0 = 1; wb_idx0 = 4'd3; wb_data0 = 64'hDEAD;
    tick();
`ifdef WB_BYPASS_EN
    check_val("raw_bypass_rdy", last_rdy, 1);
    check_val("raw_bypass_val", out_rm_val, 64'hDEAD);
    in_valid = 0; wb_we0 = 0;
    tick();
`else
    check_val("raw_wb_cycle_rdy", last_rdy, 0);
    wb_we0 = 0;
    tick();
    check_val("raw_after_rdy", last_rdy, 1);
    check_val("raw_after_val", out_rm_val, 64'hDEAD);
`endif
    drain();

    // MUL dual writeback
    out_ready = 1;
    send(8'd247, 4'd9, 4'd10, 64'h300);
    tick();
    in_valid = 0;
    tick();
    wb_we0 = 1; wb_idx0 = 4'd0; wb_data0 = 64'd5;
    wb_we1 = 1; wb_idx1 = 4'd2; wb_data1 = 64'd7;
    tick();
    wb_we0 = 0; wb_we1 = 0;
    send(8'd137, 4'd0, 4'd2, 64'h308);
    tick();
    check_val("mul_rdy", last_rdy, 1);
    check_val("mul_rax", out_reg_val, 64'd5);
    check_val("mul_rdx", out_rm_val, 64'd7);
    check_val("mul_rax_port", out_rax_val, 64'd5);

    // Same-index collision
    in_valid = 0;
    wb_we0 = 1; wb_idx0 = 4'd6; wb_data0 = 64'd1;
    wb_we1 = 1; wb_idx1 = 4'd6; wb_data1 = 64'd2;
    tick();
    wb_we0 = 0; wb_we1 = 0;
    send(8'd137, 4'd6, 4'd6, 64'h400);
    tick();
    check_val("collide_val", out_reg_val, 64'd2);
    drain();

    // Backpressure
    out_ready = 0;
    send(8'd137, 4'd1, 4'd1, 64'h111);
    tick();
    send(8'd137, 4'd2, 4'd2, 64'h222);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("bp_rdy_low", last_rdy, 0);
      check_val("bp_pc_hold", out_pc, 64'h111);
      check_val("bp_reg_hold", out_regByte, 4'd1);
    end
    out_ready = 1;
    tick();
    check_val("bp_release_rdy", last_rdy, 1);
    check_val("bp_next_pc", out_pc, 64'h222);
    in_valid = 0;
    tick();
    check_val("bp_drained", out_valid, 0);
    drain();

    // Flush a captured pop
    out_ready = 0;
    send(8'd90, 4'd11, 4'd5, 64'h500);
    tick();
    in_valid = 0; flush = 1;
    tick();
    check_val("flush_rdy", last_rdy, 0);
    check_val("flush_valid", out_valid, 0);
    flush = 0; out_ready = 1;
    send(8'd137, 4'd4, 4'd5, 64'h508);
    tick();
    check_val("flush_no_stall", last_rdy, 1);
    drain();

    // Randomized run with occasional mid-operation reset
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset_async();
      rand_inputs();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
